fft16_out_serializer: RTL and testbench

//  Output stage directly downstream of the final radix-2 butterfly stage (stage 4) of the 16-point FFT.

---
 rtl/fft16_out_serializer_if.sv | 29 ++
 rtl/fft16_out_serializer.sv | 168 ++++++++++++++++
 tb/tb_fft16_out_serializer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft16_out_serializer_if.sv
// Bus bundle for the FFT output serializer: frame capture handshake on the
// input side and the per-bin valid/ready stream on the output side.
interface fft16_out_serializer_if #(
    parameter int OUT_W = 16
);
    logic             frame_valid;
    logic             frame_ready;
    logic [271:0]     data_i_R;
    logic [271:0]     data_i_I;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_R;
    logic [OUT_W-1:0] out_I;
    logic [3:0]       out_idx;
    logic             out_last;
    logic             frame_drop;

    // Serializer side: consumes frames, produces the beat stream.
    modport slave (
        input  frame_valid, data_i_R, data_i_I, out_ready,
        output frame_ready, out_valid, out_R, out_I, out_idx, out_last, frame_drop
    );

    // Environment side: produces frames, consumes the beat stream.
    modport master (
        output frame_valid, data_i_R, data_i_I, out_ready,
        input  frame_ready, out_valid, out_R, out_I, out_idx, out_last, frame_drop
    );
endinterface

// File: rtl/fft16_out_serializer.sv
// Output stage of the 16-point FFT. Captures a whole 16-bin complex frame in
// one cycle and streams it one bin per cycle, optionally in bit-reversed
// order, with round-half-up and saturation down to OUT_W bits. A new frame
// can be captured in the same cycle the previous frame's last bin is taken.
module fft16_out_serializer #(
    parameter int OUT_W  = 16,
    parameter bit BITREV = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    fft16_out_serializer_if.slave bus
);
    localparam int S  = 17 - OUT_W;
    localparam int SH = (S > 0) ? S : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Extract the 17-bit sample of bin k from a packed frame vector.
    function automatic logic [16:0] get_bin(input logic [271:0] vec, input logic [3:0] k);
        int unsigned base;
        base = 32'(k) * 32'd17;
        return vec[base +: 17];
    endfunction

    // Map the beat counter to the bin index emitted on that beat.
    function automatic logic [3:0] out_index(input logic [3:0] c);
        logic [3:0] idx;
        if (BITREV) begin
            idx = {c[0], c[1], c[2], c[3]};
        end else begin
            idx = c;
        end
        return idx;
    endfunction

    // Round half up by S bits, then clamp to the signed OUT_W range.
    // Only a positive value plus the rounding carry can leave the range.
    function automatic logic [OUT_W-1:0] round_sat(input logic [16:0] x);
        logic signed [17:0] ext;
        logic signed [17:0] sum;
        logic signed [17:0] y;
        logic signed [17:0] res;
        logic signed [17:0] max_v;
        logic signed [17:0] min_v;
        ext   = {x[16], x};
        max_v = (18'sd1 <<< (OUT_W - 1)) - 18'sd1;
        min_v = -(18'sd1 <<< (OUT_W - 1));
        if (S == 0) begin
            res = ext;
        end else begin
            sum = ext + (18'sd1 <<< (SH - 1));
            y   = sum >>> SH;
            if (y > max_v) begin
                res = max_v;
            end else if (y < min_v) begin
                res = min_v;
            end else begin
                res = y;
            end
        end
        return res[OUT_W-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [271:0]     cap_r_q, cap_r_d;
    logic [271:0]     cap_i_q, cap_i_d;
    logic [OUT_W-1:0] out_r_q, out_r_d;
    logic [OUT_W-1:0] out_i_q, out_i_d;
    logic             frame_drop_q, frame_drop_d;
    logic             frame_ready_s;
    logic             capture_s;
    logic             beat_s;
    logic [OUT_W-1:0] load_r_s;
    logic [OUT_W-1:0] load_i_s;

    // Next-state, counter, capture register and output-sample selection.
    always_comb begin
        frame_ready_s = (state_q == ST_IDLE) || (bus.out_ready && (cnt_q == 4'd15));
        capture_s     = bus.frame_valid && frame_ready_s;
        beat_s        = (state_q == ST_SEND) && bus.out_ready;
        // First beat of a freshly captured frame comes straight from the inputs.
        load_r_s      = round_sat(get_bin(bus.data_i_R, out_index(4'd0)));
        load_i_s      = round_sat(get_bin(bus.data_i_I, out_index(4'd0)));

        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_r_d      = cap_r_q;
        cap_i_d      = cap_i_q;
        out_r_d      = out_r_q;
        out_i_d      = out_i_q;
        frame_drop_d = bus.frame_valid && !frame_ready_s;

        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    state_d = ST_SEND;
                    cnt_d   = 4'd0;
                    cap_r_d = bus.data_i_R;
                    cap_i_d = bus.data_i_I;
                    out_r_d = load_r_s;
                    out_i_d = load_i_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (beat_s) begin
                    if (cnt_q == 4'd15) begin
                        if (capture_s) begin
                            state_d = ST_SEND;
                            cnt_d   = 4'd0;
                            cap_r_d = bus.data_i_R;
                            cap_i_d = bus.data_i_I;
                            out_r_d = load_r_s;
                            out_i_d = load_i_s;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        out_r_d = round_sat(get_bin(cap_r_q, out_index(cnt_q + 4'd1)));
                        out_i_d = round_sat(get_bin(cap_i_q, out_index(cnt_q + 4'd1)));
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            cap_r_q      <= 272'd0;
            cap_i_q      <= 272'd0;
            out_r_q      <= '0;
            out_i_q      <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_r_q      <= cap_r_d;
            cap_i_q      <= cap_i_d;
            out_r_q      <= out_r_d;
            out_i_q      <= out_i_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign bus.frame_ready = frame_ready_s;
    assign bus.out_valid   = (state_q == ST_SEND);
    assign bus.out_idx     = out_index(cnt_q);
    assign bus.out_last    = (state_q == ST_SEND) && (cnt_q == 4'd15);
    assign bus.out_R       = out_r_q;
    assign bus.out_I       = out_i_q;
    assign bus.frame_drop  = frame_drop_q;
endmodule

// File: tb/tb_fft16_out_serializer.sv
// Self-checking bench: three serializer configurations (17-bit natural,
// 16-bit natural, 12-bit bit-reversed) share one stimulus and are compared
// every cycle against a queue-of-beats reference model.
module tb_fft16_out_serializer;
    logic         clk = 1'b0;
    logic         rst;
    logic         frame_valid;
    logic         out_ready;
    logic [271:0] data_r;
    logic [271:0] data_i;
    int           vectors = 0;
    int           miscompares = 0;

    fft16_out_serializer_if #(.OUT_W(17)) if_a ();
    fft16_out_serializer_if #(.OUT_W(16)) if_b ();
    fft16_out_serializer_if #(.OUT_W(12)) if_c ();

    assign if_a.frame_valid = frame_valid;
    assign if_a.data_i_R    = data_r;
    assign if_a.data_i_I    = data_i;
    assign if_a.out_ready   = out_ready;
    assign if_b.frame_valid = frame_valid;
    assign if_b.data_i_R    = data_r;
    assign if_b.data_i_I    = data_i;
    assign if_b.out_ready   = out_ready;
    assign if_c.frame_valid = frame_valid;
    assign if_c.data_i_R    = data_r;
    assign if_c.data_i_I    = data_i;
    assign if_c.out_ready   = out_ready;

    fft16_out_serializer #(.OUT_W(17), .BITREV(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    fft16_out_serializer #(.OUT_W(16), .BITREV(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    fft16_out_serializer #(.OUT_W(12), .BITREV(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    always #5 clk = ~clk;

    // One expected output beat, with the data each configuration should show.
    typedef struct {
        int pos;
        int ra;
        int ia;
        int rb;
        int ib;
        int idx_c;
        int rc;
        int ic;
    } beat_t;

    typedef struct {
        int x;
        int e16;
        int e12;
    } rnd_vec_t;

    beat_t    q[$];
    bit       m_drop;
    int       rev_tbl[16];
    rnd_vec_t tbl[16];
    int       r[16];
    int       im[16];
    int       pat[4];

    function automatic int ref_round(input int x, input int w);
        int s, y, hi, lo;
        if (w >= 17) return x;
        s  = 17 - w;
        y  = (x + (1 << (s - 1))) >>> s;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return y;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_frame();
        for (int k = 0; k < 16; k++) begin
            data_r[17*k +: 17] = 17'(r[k]);
            data_i[17*k +: 17] = 17'(im[k]);
        end
    endtask

    task automatic random_frame();
        int edges[5];
        edges = '{65535, -65536, -1, 0, 65520};
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 7) == 0) r[k] = edges[$urandom_range(0, 4)];
            else r[k] = int'($urandom_range(0, 131071)) - 65536;
            if ($urandom_range(0, 7) == 0) im[k] = edges[$urandom_range(0, 4)];
            else im[k] = int'($urandom_range(0, 131071)) - 65536;
        end
        set_frame();
    endtask

    task automatic push_frame();
        int    xr[16];
        int    xi[16];
        beat_t bt;
        for (int k = 0; k < 16; k++) begin
            xr[k] = int'($signed(data_r[17*k +: 17]));
            xi[k] = int'($signed(data_i[17*k +: 17]));
        end
        for (int b = 0; b < 16; b++) begin
            bt.pos   = b;
            bt.ra    = xr[b];
            bt.ia    = xi[b];
            bt.rb    = ref_round(xr[b], 16);
            bt.ib    = ref_round(xi[b], 16);
            bt.idx_c = rev_tbl[b];
            bt.rc    = ref_round(xr[rev_tbl[b]], 12);
            bt.ic    = ref_round(xi[rev_tbl[b]], 12);
            q.push_back(bt);
        end
    endtask

    task automatic model_update();
        bit fr;
        if (rst) begin
            q.delete();
            m_drop = 1'b0;
        end else begin
            fr     = (q.size() == 0) || (out_ready && q.size() == 1);
            m_drop = frame_valid && !fr;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (frame_valid && fr) push_frame();
        end
    endtask

    task automatic check_model();
        int    v, rdy, last, ia, ic;
        beat_t h;
        v   = (q.size() != 0) ? 1 : 0;
        rdy = ((q.size() == 0) || (out_ready && q.size() == 1)) ? 1 : 0;
        if (v != 0) begin
            h    = q[0];
            last = (h.pos == 15) ? 1 : 0;
            ia   = h.pos;
            ic   = h.idx_c;
        end else begin
            last = 0;
            ia   = 0;
            ic   = 0;
        end
        cmp("a.out_valid", int'(if_a.out_valid), v);
        cmp("b.out_valid", int'(if_b.out_valid), v);
        cmp("c.out_valid", int'(if_c.out_valid), v);
        cmp("a.frame_ready", int'(if_a.frame_ready), rdy);
        cmp("b.frame_ready", int'(if_b.frame_ready), rdy);
        cmp("c.frame_ready", int'(if_c.frame_ready), rdy);
        cmp("a.out_last", int'(if_a.out_last), last);
        cmp("c.out_last", int'(if_c.out_last), last);
        cmp("a.out_idx", int'(if_a.out_idx), ia);
        cmp("b.out_idx", int'(if_b.out_idx), ia);
        cmp("c.out_idx", int'(if_c.out_idx), ic);
        cmp("a.frame_drop", int'(if_a.frame_drop), int'(m_drop));
        cmp("c.frame_drop", int'(if_c.frame_drop), int'(m_drop));
        if (v != 0) begin
            cmp("a.out_R", int'($signed(if_a.out_R)), h.ra);
            cmp("a.out_I", int'($signed(if_a.out_I)), h.ia);
            cmp("b.out_R", int'($signed(if_b.out_R)), h.rb);
            cmp("b.out_I", int'($signed(if_b.out_I)), h.ib);
            cmp("c.out_R", int'($signed(if_c.out_R)), h.rc);
            cmp("c.out_I", int'($signed(if_c.out_I)), h.ic);
        end
    endtask

    // Inputs are set before calling; checks happen mid low phase.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rev_tbl = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        tbl = '{'{65535, 32767, 2047}, '{-3, -1, 0}, '{3, 2, 0}, '{-65536, -32768, -2048},
                '{0, 0, 0}, '{1, 1, 0}, '{-1, 0, 0}, '{16, 8, 1},
                '{15, 8, 0}, '{-16, -8, 0}, '{-17, -8, -1}, '{65519, 32760, 2047},
                '{65520, 32760, 2047}, '{1000, 500, 31}, '{-1000, -500, -31}, '{12345, 6173, 386}};
        pat = '{1, 0, 0, 1};

        // Reset state
        rst = 1'b1; frame_valid = 1'b0; out_ready = 1'b0;
        data_r = 272'd0; data_i = 272'd0;
        @(posedge clk); @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("rst.a.out_valid", int'(if_a.out_valid), 0);
        cmp("rst.a.frame_ready", int'(if_a.frame_ready), 1);
        cmp("rst.a.out_idx", int'(if_a.out_idx), 0);
        cmp("rst.a.out_last", int'(if_a.out_last), 0);
        cmp("rst.a.out_R", int'($signed(if_a.out_R)), 0);
        cmp("rst.b.out_I", int'($signed(if_b.out_I)), 0);
        cmp("rst.c.frame_drop", int'(if_c.frame_drop), 0);

        // Rounding / saturation table, streamed with out_ready held high
        for (int k = 0; k < 16; k++) begin
            r[k]  = tbl[k].x;
            im[k] = tbl[15-k].x;
        end
        set_frame();
        frame_valid = 1'b1; out_ready = 1'b1;
        step();
        frame_valid = 1'b0;
        for (int b = 0; b < 16; b++) begin
            #1;
            cmp("tbl.a.R", int'($signed(if_a.out_R)), tbl[b].x);
            cmp("tbl.a.I", int'($signed(if_a.out_I)), tbl[15-b].x);
            cmp("tbl.b.R", int'($signed(if_b.out_R)), tbl[b].e16);
            cmp("tbl.b.I", int'($signed(if_b.out_I)), tbl[15-b].e16);
            cmp("tbl.c.R", int'($signed(if_c.out_R)), tbl[rev_tbl[b]].e12);
            cmp("tbl.c.I", int'($signed(if_c.out_I)), tbl[15-rev_tbl[b]].e12);
            cmp("tbl.a.idx", int'(if_a.out_idx), b);
            cmp("tbl.c.idx", int'(if_c.out_idx), rev_tbl[b]);
            cmp("tbl.a.last", int'(if_a.out_last), (b == 15) ? 1 : 0);
            step();
        end
        repeat (2) step();

        // Back-pressure with out_ready pattern 1,0,0,1; frame R=k*100, I=-k
        for (int k = 0; k < 16; k++) begin
            r[k]  = k * 100;
            im[k] = -k;
        end
        set_frame();
        frame_valid = 1'b1; out_ready = 1'b1;
        step();
        frame_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 100 && got < 16; c++) begin
            out_ready = pat[c % 4][0];
            #1;
            if (if_a.out_valid && out_ready) begin
                cmp("bp.a.idx", int'(if_a.out_idx), got);
                cmp("bp.a.R", int'($signed(if_a.out_R)), got * 100);
                cmp("bp.a.I", int'($signed(if_a.out_I)), -got);
                cmp("bp.c.idx", int'(if_c.out_idx), rev_tbl[got]);
                got++;
            end
            step();
        end
        cmp("bp.beats", got, 16);
        out_ready = 1'b1;
        repeat (3) step();

        // Back-to-back frames with frame_valid held high
        for (int c = 0; c <= 32; c++) begin
            frame_valid = (c < 32);
            random_frame();
            #1;
            cmp("b2b.a.frame_ready", int'(if_a.frame_ready), (c % 16 == 0) ? 1 : 0);
            cmp("b2b.a.out_valid", int'(if_a.out_valid), (c >= 1) ? 1 : 0);
            cmp("b2b.a.frame_drop", int'(if_a.frame_drop),
                ((c >= 2 && c <= 16) || (c >= 18)) ? 1 : 0);
            step();
        end
        frame_valid = 1'b0;
        repeat (3) step();

        // Reset while beat 7 is on the bus, then a fresh frame
        random_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        repeat (7) step();
        #1;
        cmp("rstmid.a.idx_before", int'(if_a.out_idx), 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        cmp("rstmid.a.out_valid", int'(if_a.out_valid), 0);
        cmp("rstmid.a.frame_ready", int'(if_a.frame_ready), 1);
        cmp("rstmid.c.out_valid", int'(if_c.out_valid), 0);
        for (int k = 0; k < 16; k++) begin
            r[k]  = 7 * k + 3;
            im[k] = -5 * k;
        end
        set_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        #1;
        cmp("rstmid.a.restart_idx", int'(if_a.out_idx), 0);
        cmp("rstmid.a.restart_R", int'($signed(if_a.out_R)), 3);
        step();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            frame_valid = ($urandom_range(0, 2) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            random_frame();
            step();
        end
        rst = 1'b0; frame_valid = 1'b0; out_ready = 1'b1;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
